// File: rtl/traffic_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : traffic_request_arbiter
// Brief    : Synchronises/debounces NS and EW vehicle sensors, latches pending
//            requests and drives a round-robin request code to the controller.
//            Optional grant abandonment enabled by `TRAFFIC_REQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_request_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GRANT_TIMEOUT   = 16
) (
    input  logic       clka,
    input  logic       reseta,
    input  logic       ns_sensor_raw,
    input  logic       ew_sensor_raw,
    input  logic       ns_green,
    input  logic       ew_green,
    output logic [1:0] indata,
    output logic       ns_pending,
    output logic       ew_pending
);

    localparam logic [7:0] C_DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        GRANT_TIMEOUT < 1 || GRANT_TIMEOUT > 65535) begin : g_param_check
        $error("traffic_request_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_GRANT_NS = 2'b01,
        S_GRANT_EW = 2'b10
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_green;
    logic [1:0] w_pend;

    assign w_raw   = {ew_sensor_raw, ns_sensor_raw};
    assign w_green = {ew_green, ns_green};

    // Index 0 is north-south, index 1 is east-west.
    for (genvar i = 0; i < 2; i++) begin : g_sensor
        logic       r_sync1;
        logic       r_sync2;
        logic       r_deb;
        logic       r_pend;
        logic [7:0] r_cnt;
        logic       w_rise;

        assign w_rise = !r_deb && r_sync2 && (r_cnt == C_DEB_LAST);

        always_ff @(posedge clka or negedge reseta) begin
            if (!reseta) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_cnt   <= 8'd0;
                r_pend  <= 1'b0;
            end else begin
                r_sync1 <= w_raw[i];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_deb) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt == C_DEB_LAST) begin
                    r_deb <= r_sync2;
                    r_cnt <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                // Service by green beats a simultaneous new request.
                if (w_green[i]) begin
                    r_pend <= 1'b0;
                end else if (w_rise) begin
                    r_pend <= 1'b1;
                end
            end
        end

        assign w_pend[i] = r_pend;
    end

    state_t     r_state;
    logic [1:0] r_indata;
    logic       r_last_ew;
`ifdef TRAFFIC_REQ_TIMEOUT_EN
    localparam logic [15:0] C_GRANT_LAST = 16'(GRANT_TIMEOUT - 1);
    logic [15:0] r_grant_cnt;
`endif

    always_ff @(posedge clka or negedge reseta) begin
        if (!reseta) begin
            r_state   <= S_IDLE;
            r_indata  <= 2'b00;
            r_last_ew <= 1'b1;
`ifdef TRAFFIC_REQ_TIMEOUT_EN
            r_grant_cnt <= 16'd0;
`endif
        end else begin
`ifdef TRAFFIC_REQ_TIMEOUT_EN
            r_grant_cnt <= 16'd0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_pend[0] && (!w_pend[1] || r_last_ew)) begin
                        r_state  <= S_GRANT_NS;
                        r_indata <= 2'b01;
                    end else if (w_pend[1]) begin
                        r_state  <= S_GRANT_EW;
                        r_indata <= 2'b10;
                    end
                end
                S_GRANT_NS: begin
                    if (!w_pend[0]
`ifdef TRAFFIC_REQ_TIMEOUT_EN
                        || (r_grant_cnt == C_GRANT_LAST)
`endif
                    ) begin
                        r_last_ew <= 1'b0;
                        r_state   <= w_pend[1] ? S_GRANT_EW : S_IDLE;
                        r_indata  <= w_pend[1] ? 2'b10 : 2'b00;
                    end
`ifdef TRAFFIC_REQ_TIMEOUT_EN
                    else begin
                        r_grant_cnt <= r_grant_cnt + 16'd1;
                    end
`endif
                end
                S_GRANT_EW: begin
                    if (!w_pend[1]
`ifdef TRAFFIC_REQ_TIMEOUT_EN
                        || (r_grant_cnt == C_GRANT_LAST)
`endif
                    ) begin
                        r_last_ew <= 1'b1;
                        r_state   <= w_pend[0] ? S_GRANT_NS : S_IDLE;
                        r_indata  <= w_pend[0] ? 2'b01 : 2'b00;
                    end
`ifdef TRAFFIC_REQ_TIMEOUT_EN
                    else begin
                        r_grant_cnt <= r_grant_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_indata <= 2'b00;
                end
            endcase
        end
    end

    assign indata     = r_indata;
    assign ns_pending = w_pend[0];
    assign ew_pending = w_pend[1];

endmodule
`default_nettype wire

// File: tb/tb_traffic_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_request_arbiter
// Brief    : Directed self-checking bench for traffic_request_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_request_arbiter;

    logic       clka;
    logic       reseta;
    logic       ns_sensor_raw;
    logic       ew_sensor_raw;
    logic       ns_green;
    logic       ew_green;
    logic [1:0] indata;
    logic       ns_pending;
    logic       ew_pending;

    int total;
    int bad;

    traffic_request_arbiter #(
        .DEBOUNCE_CYCLES (4),
        .GRANT_TIMEOUT   (16)
    ) u_dut (
        .clka          (clka),
        .reseta        (reseta),
        .ns_sensor_raw (ns_sensor_raw),
        .ew_sensor_raw (ew_sensor_raw),
        .ns_green      (ns_green),
        .ew_green      (ew_green),
        .indata        (indata),
        .ns_pending    (ns_pending),
        .ew_pending    (ew_pending)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reseta        = 1'b0;
        ns_sensor_raw = 1'b1;
        ew_sensor_raw = 1'b1;
        ns_green      = 1'b0;
        ew_green      = 1'b0;

        // Reset held with both sensors active.
        repeat (3) tick();
        check("rst_indata", indata, 2'b00);
        check("rst_ns_pend", {1'b0, ns_pending}, 2'b00);
        check("rst_ew_pend", {1'b0, ew_pending}, 2'b00);

        // NS alone: pending at edge 6, grant at edge 7.
        ew_sensor_raw = 1'b0;
        reseta        = 1'b1;
        repeat (5) tick();
        check("ns_pend_e5", {1'b0, ns_pending}, 2'b00);
        tick();
        check("ns_pend_e6", {1'b0, ns_pending}, 2'b01);
        check("indata_e6", indata, 2'b00);
        tick();
        check("indata_e7", indata, 2'b01);
        check("ew_pend_e7", {1'b0, ew_pending}, 2'b00);
        ns_green = 1'b1;
        tick();
        check("ns_served_pend", {1'b0, ns_pending}, 2'b00);
        check("ns_served_hold", indata, 2'b01);
        ns_green = 1'b0;
        tick();
        check("ns_served_idle", indata, 2'b00);

        // Short EW glitch is filtered.
        ns_sensor_raw = 1'b0;
        repeat (8) tick();
        ew_sensor_raw = 1'b1;
        repeat (3) tick();
        ew_sensor_raw = 1'b0;
        repeat (10) tick();
        check("glitch_ew_pend", {1'b0, ew_pending}, 2'b00);
        check("glitch_indata", indata, 2'b00);

        // Simultaneous requests: NS first, then EW with no idle gap.
        reseta = 1'b0;
        tick();
        reseta        = 1'b1;
        ns_sensor_raw = 1'b1;
        ew_sensor_raw = 1'b1;
        repeat (6) tick();
        check("tie_pend_both", {ew_pending, ns_pending}, 2'b11);
        check("tie_indata_e6", indata, 2'b00);
        tick();
        check("tie_grant_ns", indata, 2'b01);
        ns_green = 1'b1;
        tick();
        check("tie_ns_cleared", {ew_pending, ns_pending}, 2'b10);
        check("tie_still_ns", indata, 2'b01);
        ns_green = 1'b0;
        tick();
        check("tie_handover_ew", indata, 2'b10);
        ew_green = 1'b1;
        tick();
        check("tie_ew_cleared", {ew_pending, ns_pending}, 2'b00);
        check("tie_ew_hold", indata, 2'b10);
        ew_green = 1'b0;
        tick();
        check("tie_idle", indata, 2'b00);

        // New EW request, then asynchronous reset between edges.
        ew_sensor_raw = 1'b0;
        repeat (8) tick();
        ew_sensor_raw = 1'b1;
        repeat (7) tick();
        check("ew_grant", indata, 2'b10);
        check("ew_grant_pend", {ew_pending, ns_pending}, 2'b10);
        #3;
        reseta = 1'b0;
        #1;
        check("async_rst_indata", indata, 2'b00);
        check("async_rst_pend", {ew_pending, ns_pending}, 2'b00);

        // Green already high when NS request would latch.
        ew_sensor_raw = 1'b0;
        ns_green      = 1'b1;
        #1;
        reseta = 1'b1;
        tick();
        repeat (8) tick();
        check("clr_wins_pend", {1'b0, ns_pending}, 2'b00);
        check("clr_wins_indata", indata, 2'b00);
        ns_green = 1'b0;
        repeat (2) tick();
        check("clr_wins_after", {1'b0, ns_pending}, 2'b00);

        // Both pending, never served: timeout behaviour or indefinite hold.
        reseta        = 1'b0;
        ns_sensor_raw = 1'b1;
        ew_sensor_raw = 1'b1;
        tick();
        reseta = 1'b1;
        repeat (7) tick();
        check("stall_grant_ns", indata, 2'b01);
`ifdef TRAFFIC_REQ_TIMEOUT_EN
        repeat (15) tick();
        check("to_hold_ns", indata, 2'b01);
        tick();
        check("to_switch_ew", indata, 2'b10);
        check("to_ns_still_pend", {ew_pending, ns_pending}, 2'b11);
`else
        repeat (20) tick();
        check("stall_hold_ns", indata, 2'b01);
        check("stall_pend", {ew_pending, ns_pending}, 2'b11);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
